// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters/memory (master side) and the arbiter (slave side).
interface mem_arbiter_if;
    // Instruction fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    // Data load/store port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    // Shared memory port
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_in;
    logic        mem_memwr;
    logic [31:0] mem_out;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        output if_ack, if_rvalid, if_rdata, if_err,
               d_ack, d_rvalid, d_rdata, d_err,
               mem_raddr, mem_waddr, mem_in, mem_memwr
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        input  if_ack, if_rvalid, if_rdata, if_err,
               d_ack, d_rvalid, d_rdata, d_err,
               mem_raddr, mem_waddr, mem_in, mem_memwr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter and access sequencer for a shared
// word-organised memory. Each access runs accept -> issue -> response.
// Fetch is forced after STARVE_MAX consecutive data grants while fetch waits.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES  = 1376,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

    localparam int unsigned        CNT_W     = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STARVE_MAX);
    localparam logic [31:0]        LAST_WORD = 32'(MEM_BYTES - 4);

    // Misaligned or beyond the last full word of the memory.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_WORD);
    endfunction

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    src_t              src_q,    src_d;
    logic [31:0]       addr_q,   addr_d;
    logic              we_q,     we_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic              err_q,    err_d;

    logic              if_ack_q,    if_ack_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [31:0]       if_rdata_q,  if_rdata_d;
    logic              if_err_q,    if_err_d;
    logic              d_ack_q,     d_ack_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic [31:0]       d_rdata_q,   d_rdata_d;
    logic              d_err_q,     d_err_d;
    logic [31:0]       mem_raddr_q, mem_raddr_d;
    logic [31:0]       mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_in_q,    mem_in_d;
    logic              mem_memwr_q, mem_memwr_d;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        if_ack_d    = 1'b0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        mem_raddr_d = mem_raddr_q;
        mem_waddr_d = mem_waddr_q;
        mem_in_d    = mem_in_q;
        mem_memwr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.if_req) begin
                    cnt_d = '0;
                end
                if (bus.if_req && (!bus.d_req || cnt_q == CNT_MAX)) begin
                    src_d    = SRC_FETCH;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    err_d    = addr_err(bus.if_addr);
                    if_ack_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end else if (bus.d_req) begin
                    src_d   = SRC_DATA;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    err_d   = addr_err(bus.d_addr);
                    d_ack_d = 1'b1;
                    if (bus.if_req && cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A bad address never reaches the memory; its port keeps the old values.
                if (!err_q) begin
                    mem_raddr_d = addr_q;
                    mem_waddr_d = addr_q;
                    mem_in_d    = wdata_q;
                    mem_memwr_d = we_q;
                end
                state_d = RESP;
            end
            RESP: begin
                if (src_q == SRC_FETCH) begin
                    if_rvalid_d = 1'b1;
                    if_err_d    = err_q;
                    if_rdata_d  = err_q ? 32'h0 : bus.mem_out;
                end else begin
                    d_rvalid_d = 1'b1;
                    d_err_d    = err_q;
                    d_rdata_d  = (err_q || we_q) ? 32'h0 : bus.mem_out;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= SRC_FETCH;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            if_ack_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_in_q    <= '0;
            mem_memwr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            if_ack_q    <= if_ack_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_ack_q     <= d_ack_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            mem_raddr_q <= mem_raddr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_in_q    <= mem_in_d;
            mem_memwr_q <= mem_memwr_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_raddr = mem_raddr_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_in    = mem_in_q;
    assign bus.mem_memwr = mem_memwr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: falling-edge memory model, word-array reference
// memory, per-feature tasks with inline comparisons.
module tb_mem_arbiter;

    localparam int MEM_BYTES  = 1376;
    localparam int STARVE_MAX = 4;
    localparam int WORDS      = MEM_BYTES / 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: samples on the falling edge, with a preload port.
    logic [31:0] mem [WORDS];
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;
    int          memwr_cycles = 0;

    always @(negedge clk) begin
        int widx;
        int ridx;
        widx = int'(bus.mem_waddr >> 2);
        ridx = int'(bus.mem_raddr >> 2);
        if (pl_en) mem[int'(pl_addr >> 2)] <= pl_data;
        else if (bus.mem_memwr && widx < WORDS) mem[widx] <= bus.mem_in;
        if (bus.mem_memwr) memwr_cycles <= memwr_cycles + 1;
        bus.mem_out <= (ridx < WORDS) ? mem[ridx] : 32'h0;
    end

    // Reference memory contents as the requesters should see them.
    logic [31:0] ref_mem [WORDS];

    logic [166:0] all_outs;
    assign all_outs = {bus.if_ack, bus.if_rvalid, bus.if_rdata, bus.if_err,
                       bus.d_ack, bus.d_rvalid, bus.d_rdata, bus.d_err,
                       bus.mem_raddr, bus.mem_waddr, bus.mem_in, bus.mem_memwr};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        ref_mem[addr / 4] = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One complete access from either requester, checked against ref_mem.
    task automatic access(input string tag, input bit fetch, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit          exp_err;
        bit          exp_wr;
        bit          got;
        logic [31:0] exp_rdata;
        logic [31:0] other_hold;
        int          wr0;
        exp_err   = (addr % 4 != 0) || (addr > MEM_BYTES - 4);
        exp_wr    = !fetch && we && !exp_err;
        exp_rdata = 32'h0;
        if (!exp_err && (fetch || !we)) exp_rdata = ref_mem[addr / 4];
        other_hold = fetch ? bus.d_rdata : bus.if_rdata;
        wr0 = memwr_cycles;
        if (fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (fetch ? bus.if_ack : bus.d_ack) begin
                got = 1'b1;
                break;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s ack: got no ack, required ack within 20 cycles", tag);
            return;
        end
        // T+1: issue cycle seen on the memory port
        @(posedge clk); #1;
        n_checks++;
        if ({bus.if_ack, bus.d_ack, bus.if_rvalid, bus.d_rvalid, bus.mem_memwr} !== {4'b0000, exp_wr}) begin
            n_fail++;
            $display("FAIL %s issue: ack/ack/rv/rv/memwr got %b, required %b", tag,
                     {bus.if_ack, bus.d_ack, bus.if_rvalid, bus.d_rvalid, bus.mem_memwr}, {4'b0000, exp_wr});
        end
        if (exp_wr) begin
            n_checks++;
            if (bus.mem_waddr !== addr || bus.mem_in !== wdata) begin
                n_fail++;
                $display("FAIL %s wr_port: waddr/in got %h/%h, required %h/%h", tag,
                         bus.mem_waddr, bus.mem_in, addr, wdata);
            end
        end
        // T+2: response
        @(posedge clk); #1;
        n_checks++;
        if (fetch) begin
            if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.if_rdata, bus.d_rdata}
                !== {2'b10, exp_err, 1'b0, exp_rdata, other_hold}) begin
                n_fail++;
                $display("FAIL %s resp: rv=%b%b err=%b%b rdata=%h other=%h, required rv=10 err=%b0 rdata=%h other=%h",
                         tag, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.if_rdata, bus.d_rdata,
                         exp_err, exp_rdata, other_hold);
            end
        end else begin
            if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.d_rdata, bus.if_rdata}
                !== {2'b01, 1'b0, exp_err, exp_rdata, other_hold}) begin
                n_fail++;
                $display("FAIL %s resp: rv=%b%b err=%b%b rdata=%h other=%h, required rv=01 err=0%b rdata=%h other=%h",
                         tag, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.d_rdata, bus.if_rdata,
                         exp_err, exp_rdata, other_hold);
            end
        end
        // T+3: pulses gone, write count settled
        @(posedge clk); #1;
        n_checks++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.mem_memwr} !== 5'b0 ||
            memwr_cycles - wr0 != int'(exp_wr)) begin
            n_fail++;
            $display("FAIL %s after: pulses=%b memwr_cycles=%0d, required pulses=00000 memwr_cycles=%0d", tag,
                     {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.mem_memwr},
                     memwr_cycles - wr0, int'(exp_wr));
        end
        if (exp_wr) ref_mem[addr / 4] = wdata;
    endtask

    task automatic test_reset();
        for (int i = 0; i < WORDS; i++) preload(32'(i * 4), $urandom);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs);
        end
    endtask

    task automatic test_fetch();
        preload(32'd8, 32'h11223344);
        access("fetch_8", 1'b1, 1'b0, 32'd8, 32'h0);
        access("fetch_100", 1'b1, 1'b0, 32'd100, 32'h0);
    endtask

    task automatic test_store_load();
        access("store_0x40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        access("load_0x40",  1'b0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_starvation();
        string order;
        int    n_f_rsp;
        int    n_d_rsp;
        bit    both;
        bit    bad_data;
        logic [31:0] fa;
        logic [31:0] da;
        order = "";
        n_f_rsp = 0;
        n_d_rsp = 0;
        both = 1'b0;
        bad_data = 1'b0;
        fa = 32'd8;
        da = 32'h40;
        bus.if_req = 1'b1; bus.if_addr = fa;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
        for (int i = 0; i < 200 && order.len() < 10; i++) begin
            @(posedge clk); #1;
            if (bus.if_ack && bus.d_ack) both = 1'b1;
            if (bus.if_ack) order = {order, "F"};
            if (bus.d_ack) order = {order, "D"};
            if (bus.if_rvalid) begin
                n_f_rsp++;
                if (bus.if_rdata !== ref_mem[fa / 4]) bad_data = 1'b1;
            end
            if (bus.d_rvalid) begin
                n_d_rsp++;
                if (bus.d_rdata !== ref_mem[da / 4]) bad_data = 1'b1;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.if_rvalid) begin
                n_f_rsp++;
                if (bus.if_rdata !== ref_mem[fa / 4]) bad_data = 1'b1;
            end
            if (bus.d_rvalid) begin
                n_d_rsp++;
                if (bus.d_rdata !== ref_mem[da / 4]) bad_data = 1'b1;
            end
        end
        n_checks++;
        if (order != "DDDDFDDDDF" || both) begin
            n_fail++;
            $display("FAIL starve_order: got %s (both=%b), required DDDDFDDDDF", order, both);
        end
        n_checks++;
        if (n_f_rsp != 2 || n_d_rsp != 8 || bad_data) begin
            n_fail++;
            $display("FAIL starve_resp: got F=%0d D=%0d bad_data=%b, required F=2 D=8 bad_data=0",
                     n_f_rsp, n_d_rsp, bad_data);
        end
    endtask

    task automatic test_errors();
        access("load_0x41",   1'b0, 1'b0, 32'h41, 32'h0);
        access("load_1374",   1'b0, 1'b0, 32'd1374, 32'h0);
        access("store_1374",  1'b0, 1'b1, 32'd1374, 32'h5A5A5A5A);
        access("store_0x42",  1'b0, 1'b1, 32'h42, 32'hA5A5A5A5);
        access("fetch_6",     1'b1, 1'b0, 32'd6, 32'h0);
        access("fetch_1376",  1'b1, 1'b0, 32'd1376, 32'h0);
        access("load_1372",   1'b0, 1'b0, 32'd1372, 32'h0);
        access("store_1372",  1'b0, 1'b1, 32'd1372, 32'hCAFEF00D);
        access("reload_1372", 1'b0, 1'b0, 32'd1372, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit          f;
            bit          w;
            logic [31:0] a;
            f = 1'($urandom_range(0, 1));
            w = !f && 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, WORDS - 1) * 4);
            access($sformatf("rand_%0d", i), f, w, a, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        bit          got;
        bit          saw_pulse;
        a = 32'h80;
        got = 1'b0;
        saw_pulse = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = a; bus.d_wdata = ~ref_mem[a / 4];
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.d_ack) begin
                got = 1'b1;
                break;
            end
        end
        bus.d_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_mid_ack: got no ack, required ack within 20 cycles");
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.mem_memwr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_memwr_before: got %b, required 1", bus.mem_memwr);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h, required 0", all_outs);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.if_rvalid || bus.d_rvalid || bus.mem_memwr) saw_pulse = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.if_rvalid || bus.d_rvalid || bus.mem_memwr) saw_pulse = 1'b1;
        end
        n_checks++;
        if (saw_pulse) begin
            n_fail++;
            $display("FAIL rst_mid_no_resp: got a response/write pulse, required none");
        end
        access("rst_readback", 1'b0, 1'b0, a, 32'h0);
        access("rst_store",    1'b0, 1'b1, 32'h84, 32'h12345678);
        access("rst_load",     1'b0, 1'b0, 32'h84, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        @(posedge clk); #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_fetch();
        test_store_load();
        test_starvation();
        test_errors();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared 32-bit byte-addressed, little-endian memory.
- Requester 0 is instruction fetch (read-only); requester 1 is the data load/store port.
- Sequences each access as accept -> issue -> response, and returns read data with a fixed latency.
- Guards the memory against out-of-range and misaligned accesses, and bounds fetch starvation.

Parameters:
- MEM_BYTES, 1376, memory size in bytes; the last legal word address is MEM_BYTES-4.
- STARVE_MAX, 4, maximum consecutive data grants while fetch is pending before fetch is forced.

Ports:
- clk  in  1  system clock; the memory samples on the falling edge, this block works on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err are valid.
- if_rdata  out  32  fetched word.
- if_err  out  1  fetch address was misaligned or out of range.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: response is valid (for loads and for stores).
- d_rdata  out  32  load data; 0 for stores.
- d_err  out  1  data address was misaligned or out of range.
- mem_raddr  out  32  memory read address.
- mem_waddr  out  32  memory write address.
- mem_in  out  32  memory write data.
- mem_memwr  out  1  memory write enable.
- mem_out  in  32  memory read data.

Behaviour:
- Clocking: clk is the single clock; rst_n is asynchronous and active-low.
- Reset: state=IDLE, starvation counter=0. All outputs are 0, including mem_memwr, all addresses, data and the ack/rvalid/err pulses.
- Reset mid-access: the in-flight request is dropped with no response pulse. mem_memwr deasserts immediately on reset.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Arbitrate and pulse the winner's ack for one cycle.
  - Latch the winner id, address, we and wdata.
  - Compute err = (addr[1:0] != 0) || (addr > MEM_BYTES-4).
  - Go to ISSUE.
- ISSUE, err=0:
  - mem_raddr = mem_waddr = latched address; mem_in = latched wdata.
  - mem_memwr = 1 only for a data store.
  - The memory samples on the falling edge inside this cycle.
- ISSUE, err=1: mem_memwr stays 0 and the addresses hold their previous values.
- ISSUE always goes to RESP.
- RESP:
  - Pulse the winner's rvalid.
  - rdata = mem_out for a load or fetch with err=0; otherwise rdata = 0.
  - err is presented with rvalid.
  - mem_memwr = 0. Go to IDLE.
- Latency: ack at cycle T, rvalid at cycle T+2. Peak throughput is one access per 3 cycles.
- Arbitration:
  - Data wins by default.
  - If fetch is pending and the counter equals STARVE_MAX, fetch wins.
- Starvation counter:
  - Increments on each data grant while if_req=1.
  - Resets to 0 on any fetch grant, or on any IDLE cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Requester's side: req must stay asserted with stable fields until the ack pulse. The requester may drop or change its request the cycle after the ack.
- Non-winner: receives no ack and keeps waiting. Its request is evaluated again in the next IDLE.
- Read during write: not possible, since only one access is in flight.
- Unselected response outputs: if_rdata and d_rdata hold their last value. if_rvalid, d_rvalid, if_err and d_err are 0 outside their pulse.

Test Plan:
- Preload the memory with word 0x11223344 at byte 8. Fetch at 8 -> if_ack at T, if_rvalid at T+2, if_rdata=0x11223344, if_err=0.
- Store 0xDEADBEEF to 0x40, then load 0x40:
  - The store cycle has mem_memwr=1 for exactly one cycle with mem_waddr=0x40, followed by d_rvalid with d_rdata=0.
  - The load returns 0xDEADBEEF.
- Hold if_req and d_req asserted continuously with STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F. No ack is ever lost.
- Load at 0x41 and at MEM_BYTES-2 (1374) -> d_err=1 and d_rdata=0. mem_memwr never asserts, and the contents at 1372 are unchanged.
- Store at 1372 (MEM_BYTES-4) -> accepted with d_err=0. A readback of 1372 returns the stored word.
- Assert rst_n=0 during ISSUE of a store:
  - All outputs go to 0 asynchronously; no rvalid is produced and mem_memwr drops at once.
  - After release, the FSM is in IDLE and the next request follows normal timing.
